// File: rtl/input_skew_array_pkg.sv
// Shared definitions for the systolic input feeder: read-FSM encoding,
// counter width helpers and the lane slice position used by both array edges.
package input_skew_array_pkg;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_DRAIN = 1'b1
    } rd_state_e;

    // Row counter width; a one-bit minimum keeps degenerate sizes legal.
    function automatic int cnt_w(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    function automatic int step_w(input int size);
        return $clog2(2 * size - 1);
    endfunction

    // MSB of lane `lane` inside a packed vector; lane 0 occupies the top slice.
    function automatic int lane_msb(input int data_width, input int size, input int lane);
        return data_width * (size - lane) - 1;
    endfunction

endpackage

// File: rtl/input_skew_array_bank.sv
// Ping-pong pair of SIZExSIZE operand banks: one full-row write port and a
// per-lane read port so every lane can fetch a different row in the same cycle.
module pingpong_tile_bank
    import input_skew_array_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SIZE       = 8,
    parameter int CNT_W      = 3
) (
    input  logic                       clk,
    input  logic                       wr_en_i,
    input  logic                       wr_sel_i,
    input  logic [CNT_W-1:0]           wr_row_i,
    input  logic [DATA_WIDTH*SIZE-1:0] wr_data_i,
    input  logic                       rd_sel_i,
    input  logic [SIZE*CNT_W-1:0]      rd_row_i,
    output logic [DATA_WIDTH*SIZE-1:0] rd_data_o
);

    // Operand storage carries no reset; stale rows are masked by the reader.
    logic [DATA_WIDTH*SIZE-1:0] bank_q [2][SIZE];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            bank_q[wr_sel_i][wr_row_i] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < SIZE; i++) begin
            rd_data_o[lane_msb(DATA_WIDTH, SIZE, i) -: DATA_WIDTH] =
                bank_q[rd_sel_i][rd_row_i[i*CNT_W +: CNT_W]][lane_msb(DATA_WIDTH, SIZE, i) -: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/input_skew_array.sv
// Input-edge feeder of the systolic array: buffers one operand tile per bank
// and replays it as a diagonal wavefront, lane i lagging lane 0 by i cycles.
module input_skew_array
    import input_skew_array_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SIZE       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH*SIZE-1:0] in_data,
    output logic [DATA_WIDTH*SIZE-1:0] out_data,
    output logic [SIZE-1:0]            out_valid,
    output logic                       tile_start,
    output logic                       tile_done
);

    localparam int                CNT_W    = cnt_w(SIZE);
    localparam int                STEP_W   = step_w(SIZE);
    localparam logic [STEP_W-1:0] T_LAST   = STEP_W'(2 * SIZE - 2);
    localparam logic [CNT_W-1:0]  ROW_LAST = CNT_W'(SIZE - 1);

    logic [1:0]                 full_q, full_d;
    logic                       wr_sel_q, wr_sel_d;
    logic                       rd_sel_q, rd_sel_d;
    logic [CNT_W-1:0]           wr_cnt_q, wr_cnt_d;
    rd_state_e                  state_q, state_d;
    logic [STEP_W-1:0]          t_q, t_d;
    logic [DATA_WIDTH*SIZE-1:0] out_data_q, out_data_d;
    logic [SIZE-1:0]            out_valid_q, out_valid_d;
    logic                       tile_start_q, tile_start_d;
    logic                       tile_done_q, tile_done_d;

    logic                       wr_fire;
    logic                       wr_last;
    logic                       drain_end;
    logic [SIZE*CNT_W-1:0]      rd_row;
    logic [SIZE-1:0]            lane_on;
    logic [DATA_WIDTH*SIZE-1:0] rd_lane;

    assign in_ready  = !full_q[wr_sel_q];
    assign wr_fire   = in_valid && in_ready;
    assign wr_last   = wr_fire && (wr_cnt_q == ROW_LAST);
    assign drain_end = (state_q == RD_DRAIN) && (t_q == T_LAST);

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        wr_sel_d = wr_sel_q;
        if (wr_fire) begin
            if (wr_last) begin
                wr_cnt_d = '0;
                wr_sel_d = !wr_sel_q;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end
    end

    // Writer sets and reader clears always address different banks, so both apply.
    always_comb begin
        full_d   = full_q;
        rd_sel_d = rd_sel_q;
        if (wr_last) begin
            full_d[wr_sel_q] = 1'b1;
        end
        if (drain_end) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = !rd_sel_q;
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        case (state_q)
            RD_IDLE: begin
                if (full_q[rd_sel_q]) begin
                    state_d = RD_DRAIN;
                    t_d     = '0;
                end
            end
            RD_DRAIN: begin
                if (t_q == T_LAST) begin
                    t_d = '0;
                    // Chain straight into the other bank when it is already waiting.
                    if (!full_q[!rd_sel_q]) begin
                        state_d = RD_IDLE;
                    end
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            default: begin
                state_d = RD_IDLE;
                t_d     = '0;
            end
        endcase
    end

    // Outputs are registered from the next step so they line up with t_q.
    always_comb begin
        rd_row  = '0;
        lane_on = '0;
        for (int i = 0; i < SIZE; i++) begin
            rd_row[i*CNT_W +: CNT_W] = CNT_W'(int'(t_d) - i);
            lane_on[i] = (state_d == RD_DRAIN) && (int'(t_d) >= i) && (int'(t_d) <= i + SIZE - 1);
        end
    end

    always_comb begin
        out_data_d   = '0;
        out_valid_d  = '0;
        tile_start_d = (state_d == RD_DRAIN) && (t_d == '0);
        tile_done_d  = (state_d == RD_DRAIN) && (t_d == T_LAST);
        for (int i = 0; i < SIZE; i++) begin
            if (lane_on[i]) begin
                out_data_d[lane_msb(DATA_WIDTH, SIZE, i) -: DATA_WIDTH] =
                    rd_lane[lane_msb(DATA_WIDTH, SIZE, i) -: DATA_WIDTH];
                out_valid_d[SIZE-1-i] = 1'b1;
            end
        end
    end

    pingpong_tile_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIZE       (SIZE),
        .CNT_W      (CNT_W)
    ) u_bank (
        .clk       (clk),
        .wr_en_i   (wr_fire),
        .wr_sel_i  (wr_sel_q),
        .wr_row_i  (wr_cnt_q),
        .wr_data_i (in_data),
        .rd_sel_i  (rd_sel_d),
        .rd_row_i  (rd_row),
        .rd_data_o (rd_lane)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q       <= '0;
            wr_sel_q     <= 1'b0;
            rd_sel_q     <= 1'b0;
            wr_cnt_q     <= '0;
            state_q      <= RD_IDLE;
            t_q          <= '0;
            out_data_q   <= '0;
            out_valid_q  <= '0;
            tile_start_q <= 1'b0;
            tile_done_q  <= 1'b0;
        end else begin
            full_q       <= full_d;
            wr_sel_q     <= wr_sel_d;
            rd_sel_q     <= rd_sel_d;
            wr_cnt_q     <= wr_cnt_d;
            state_q      <= state_d;
            t_q          <= t_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            tile_start_q <= tile_start_d;
            tile_done_q  <= tile_done_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign tile_start = tile_start_q;
    assign tile_done  = tile_done_q;

endmodule

// File: tb/tb_input_skew_array.sv
// Scoreboard bench for input_skew_array at SIZE=4, DATA_WIDTH=8:
// accepted tiles queue their expected wavefront, a monitor compares each drain step.
module tb_input_skew_array;

    localparam int DW = 8;
    localparam int SZ = 4;
    localparam int VW = DW * SZ;
    localparam int NSTEP = 2 * SZ - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [VW-1:0] in_data = '0;
    logic          in_ready;
    logic [VW-1:0] out_data;
    logic [SZ-1:0] out_valid;
    logic          tile_start;
    logic          tile_done;

    typedef struct packed {
        logic [VW-1:0] d;
        logic [SZ-1:0] v;
        logic          s;
        logic          dn;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [VW-1:0] tile_rows [SZ];
    int            wcnt = 0;
    int            errors = 0;
    int            checks = 0;

    input_skew_array #(.DATA_WIDTH(DW), .SIZE(SZ)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .tile_start (tile_start),
        .tile_done  (tile_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Row r of a tile with base b: lane i holds 8'h{b+r, i}.
    function automatic logic [VW-1:0] row_vec(input int base, input int r);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < SZ; i++) begin
            v[DW*(SZ-i)-1 -: DW] = 8'((base + r) * 16 + i);
        end
        return v;
    endfunction

    task automatic push_tile();
        exp_t e;
        for (int t = 0; t < NSTEP; t++) begin
            e = '0;
            for (int i = 0; i < SZ; i++) begin
                if (t >= i && t <= i + SZ - 1) begin
                    e.d[DW*(SZ-i)-1 -: DW] = tile_rows[t-i][DW*(SZ-i)-1 -: DW];
                    e.v[SZ-1-i] = 1'b1;
                end
            end
            e.s  = (t == 0);
            e.dn = (t == NSTEP - 1);
            sb.push_back(e);
        end
    endtask

    // Holds in_valid with v until a handshake edge, then records the beat in the model.
    task automatic send_beat(input logic [VW-1:0] v);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = v;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: got no handshake expected handshake for %0h", v);
        end else begin
            tile_rows[wcnt] = v;
            wcnt++;
            if (wcnt == SZ) begin
                push_tile();
                wcnt = 0;
            end
        end
    endtask

    task automatic send_tile(input int base);
        for (int r = 0; r < SZ; r++) begin
            send_beat(row_vec(base, r));
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 200 && sb.size() != 0; n++) begin
            @(negedge clk);
        end
        chk(name, 64'(sb.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid != '0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got out_data=%0h out_valid=%0b expected no output", out_data, out_valid);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_data",  64'(out_data),   64'(mon_e.d));
                    chk("sb_valid", 64'(out_valid),  64'(mon_e.v));
                    chk("sb_start", 64'(tile_start), 64'(mon_e.s));
                    chk("sb_done",  64'(tile_done),  64'(mon_e.dn));
                end
            end else begin
                chk("idle_data",  64'(out_data), 64'd0);
                chk("idle_flags", 64'({tile_start, tile_done}), 64'd0);
            end
        end
    end

    initial begin
        bit seen;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready",     64'(in_ready),   64'd1);
        chk("rst_out_valid", 64'(out_valid),  64'd0);
        chk("rst_out_data",  64'(out_data),   64'd0);
        chk("rst_flags",     64'({tile_start, tile_done}), 64'd0);
        rst = 1'b0;

        // Idle after reset release
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            chk("s1_ready",     64'(in_ready),  64'd1);
            chk("s1_out_valid", 64'(out_valid), 64'd0);
            chk("s1_out_data",  64'(out_data),  64'd0);
        end

        // Single tile, hand-computed wavefront points
        send_tile(0);
        @(posedge clk);
        #1;
        chk("s2_t0_start", 64'(tile_start), 64'd1);
        chk("s2_t0_data",  64'(out_data),   64'h00000000);
        chk("s2_t0_valid", 64'(out_valid),  64'b1000);
        repeat (3) @(posedge clk);
        #1;
        chk("s2_t3_data",  64'(out_data),   64'h30211203);
        chk("s2_t3_valid", 64'(out_valid),  64'b1111);
        repeat (3) @(posedge clk);
        #1;
        chk("s2_t6_data",  64'(out_data),   64'h00000033);
        chk("s2_t6_valid", 64'(out_valid),  64'b0001);
        chk("s2_t6_done",  64'(tile_done),  64'd1);
        wait_idle("s2_drained");

        // Three tiles streamed with in_valid held high
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < SZ; r++) begin
                send_beat(row_vec(4 * k, r));
            end
        end
        chk("s3_ready_low", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_data  = row_vec(8, 0);
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            seen = tile_done;
        end
        chk("s3_first_done", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        chk("s3_chain_start", 64'(tile_start), 64'd1);
        chk("s3_ready_rise",  64'(in_ready),   64'd1);
        send_tile(8);
        wait_idle("s3_drained");

        // Gappy writer: in_valid toggles, garbage data in the gaps
        for (int r = 0; r < SZ; r++) begin
            send_beat(row_vec(0, r));
            in_valid = 1'b0;
            in_data  = 32'hDEADBEEF;
            @(posedge clk);
            #1;
        end
        wait_idle("s4_drained");

        // Reset in the middle of a drain
        send_tile(0);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(posedge clk);
            #1;
            seen = tile_start;
        end
        chk("s5_start_seen", 64'(seen), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("s5_t2_data",  64'(out_data),  64'h20110200);
        chk("s5_t2_valid", 64'(out_valid), 64'b1110);
        rst = 1'b1;
        #1;
        chk("s5_rst_valid", 64'(out_valid),  64'd0);
        chk("s5_rst_data",  64'(out_data),   64'd0);
        chk("s5_rst_ready", 64'(in_ready),   64'd1);
        chk("s5_rst_flags", 64'({tile_start, tile_done}), 64'd0);
        sb.delete();
        wcnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_tile(4);
        wait_idle("s5_drained");

        // Partial tile discarded by reset
        send_beat(row_vec(8, 0));
        send_beat(row_vec(8, 1));
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        wcnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_tile(12);
        wait_idle("s6_drained");

        repeat (5) @(posedge clk);
        #1;
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
